pwm_meter: RTL and testbench

- Avalon-MM slave that measures the PWM waveform produced by the team's pwm block (duty register in percent, 50 MHz clk) and sits directly downstream of that block's pwm_out.
- Synchronises pwm_in, detects edges, and counts high time and period in clk cycles.
- Publishes the last complete measurement in read-only registers and raises an interrupt.
- Used for closed-loop checking of duty cycle in hardware and as a bench monitor.

---
 rtl/pwm_meter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pwm_meter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of a PWM waveform in clk cycles.
//
// pwm_in is synchronised, rising/falling edges are detected, and two counters
// track high time and period. The last complete measurement is published in
// read-only registers over an Avalon-MM slave, with a level interrupt.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register select (0 CTRL, 1 HIGH, 2 PERIOD, 3 STATUS)
//   chipselect  slave select
//   read        read strobe (readdata valid one cycle later)
//   write       write strobe
//   writedata   write data
//   readdata    registered read data
//   pwm_in      PWM waveform, asynchronous to clk
//   irq         level interrupt: irq_en & (valid | sat), registered
//
// FSM states:
//   state  | meaning
//   IDLE   | disabled, counters held at 0
//   ARM    | waiting for a rising edge; any partial pulse is discarded
//   HIGH   | inside the high phase, counting high time and period
//   LOW    | inside the low phase, counting period; next rise publishes
module pwm_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pwm_in,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   level_d;
  logic                   rise;
  logic                   fall;

  logic                   ctrl_en;
  logic                   ctrl_irq_en;
  logic                   valid;
  logic                   sat;

  logic [CNT_WIDTH-1:0]   hcnt;
  logic [CNT_WIDTH-1:0]   pcnt;
  logic [CNT_WIDTH-1:0]   shadow;
  logic [CNT_WIDTH-1:0]   high_reg;
  logic [CNT_WIDTH-1:0]   period_reg;
  logic                   pcnt_max;

  logic                   wr_ctrl;
  logic                   wr_stat;
  logic                   clear;

  logic                   cnt_zero;
  logic                   cnt_load;
  logic                   h_inc;
  logic                   p_inc;
  logic                   shadow_ld;
  logic                   publish;
  logic                   sat_set;

  logic                   unused_wd;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detect. Both edges see the same latency, so the
  // measured intervals equal the intervals on pwm_in.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_d <= level;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign wr_ctrl   = chipselect & write & (address == 2'd0);
  assign wr_stat   = chipselect & write & (address == 2'd3);
  assign clear     = wr_ctrl & writedata[2];
  assign unused_wd = ^writedata[31:3];
  assign pcnt_max  = &pcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en     <= writedata[0];
      ctrl_irq_en <= writedata[1];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Priority: clear, then disable, then saturation, then edge events.
  // clear takes the enable value written alongside it.
  always_comb begin
    state_nxt = state;
    cnt_zero  = 1'b0;
    cnt_load  = 1'b0;
    h_inc     = 1'b0;
    p_inc     = 1'b0;
    shadow_ld = 1'b0;
    publish   = 1'b0;
    sat_set   = 1'b0;
    if (clear) begin
      cnt_zero  = 1'b1;
      state_nxt = writedata[0] ? S_ARM : S_IDLE;
    end else if (!ctrl_en) begin
      cnt_zero  = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt_zero  = 1'b1;
          state_nxt = S_ARM;
        end
        S_ARM: begin
          if (rise) begin
            cnt_load  = 1'b1;
            state_nxt = S_HIGH;
          end else begin
            cnt_zero = 1'b1;
          end
        end
        S_HIGH: begin
          if (pcnt_max) begin
            sat_set   = 1'b1;
            cnt_zero  = 1'b1;
            state_nxt = S_ARM;
          end else begin
            h_inc = 1'b1;
            p_inc = 1'b1;
            if (fall) begin
              shadow_ld = 1'b1;
              state_nxt = S_LOW;
            end
          end
        end
        S_LOW: begin
          if (pcnt_max) begin
            sat_set   = 1'b1;
            cnt_zero  = 1'b1;
            state_nxt = S_ARM;
          end else if (rise) begin
            publish   = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = S_HIGH;
          end else begin
            p_inc = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and published registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (cnt_zero) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (cnt_load) begin
      // The rise cycle itself is the first counted cycle.
      hcnt <= CNT_WIDTH'(1);
      pcnt <= CNT_WIDTH'(1);
    end else begin
      if (h_inc) hcnt <= hcnt + CNT_WIDTH'(1);
      if (p_inc) pcnt <= pcnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow     <= '0;
      high_reg   <= '0;
      period_reg <= '0;
    end else begin
      if (shadow_ld) shadow <= hcnt;
      if (clear) begin
        high_reg   <= '0;
        period_reg <= '0;
      end else if (publish) begin
        high_reg   <= shadow;
        period_reg <= pcnt;
      end
    end
  end

  // Hardware set beats a same-cycle W1C; clear beats everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      sat   <= 1'b0;
    end else begin
      if (clear)                        valid <= 1'b0;
      else if (publish)                 valid <= 1'b1;
      else if (wr_stat && writedata[0]) valid <= 1'b0;

      if (clear)                        sat <= 1'b0;
      else if (sat_set)                 sat <= 1'b1;
      else if (wr_stat && writedata[1]) sat <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= ctrl_irq_en & (valid | sat);
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      unique case (address)
        2'd0:    readdata <= {30'b0, ctrl_irq_en, ctrl_en};
        2'd1:    readdata <= 32'(high_reg);
        2'd2:    readdata <= 32'(period_reg);
        2'd3:    readdata <= {29'b0, level, sat, valid};
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
module tb_pwm_meter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        pwm_in;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Reference model: timestamps of pwm_in edges in clk cycles.
  int cyc = 0;
  int rise_t = 0;
  int fall_t = 0;
  int last_high = 0;
  int last_period = 0;

  typedef struct {
    int h;
    int l;
    int exp_high;
    int exp_period;
  } vec_t;

  vec_t tbl[7];

  pwm_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_in     (pwm_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    step();
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address    = a;
    writedata  = v;
    chipselect = 1'b1;
    write      = 1'b1;
    step();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  // Drive pwm_in and update the model from the edge timestamps.
  task automatic pwm_set(input logic v);
    if (v && !pwm_in) begin
      last_high   = fall_t - rise_t;
      last_period = cyc - rise_t;
      rise_t      = cyc;
    end else if (!v && pwm_in) begin
      fall_t = cyc;
    end
    pwm_in = v;
  endtask

  // Consumes 3 cycles.
  task automatic check_meas(input int eh, input int ep, input int es, input logic ei);
    logic [31:0] d;
    chk("irq", {31'b0, irq}, {31'b0, ei});
    rd(2'd1, d); chk("high", d, eh);
    rd(2'd2, d); chk("period", d, ep);
    rd(2'd3, d); chk("status", d, es);
  endtask

  // One PWM period of h high / l low cycles (h >= 8). Optionally checks the
  // previously completed period during the high phase.
  task automatic run_period(input int h, input int l, input bit do_chk,
                            input bit use_model, input int eh, input int ep);
    pwm_set(1'b1);
    if (do_chk) begin
      repeat (5) step();
      if (use_model) check_meas(last_high, last_period, 5, 1'b1);
      else           check_meas(eh, ep, 5, 1'b1);
      repeat (h - 8) step();
    end else begin
      repeat (h) step();
    end
    pwm_set(1'b0);
    repeat (l) step();
  endtask

  initial begin
    logic [31:0] d;
    int prev_h;
    int prev_p;
    int rh;
    int rl;

    tbl[0] = '{70, 30, 70, 100};
    tbl[1] = '{70, 30, 70, 100};
    tbl[2] = '{70, 30, 70, 100};
    tbl[3] = '{10, 5, 10, 15};
    tbl[4] = '{8, 1, 8, 9};
    tbl[5] = '{200, 50, 200, 250};
    tbl[6] = '{9, 120, 9, 129};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    pwm_in     = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      chk("reset_read", d, 0);
    end
    chk("reset_irq", {31'b0, irq}, 0);

    // Table-driven periods
    wr(2'd0, 32'd3);
    repeat (6) step();
    prev_h = 0;
    prev_p = 0;
    for (int i = 0; i < 7; i++) begin
      run_period(tbl[i].h, tbl[i].l, i > 0, 1'b0, prev_h, prev_p);
      prev_h = tbl[i].exp_high;
      prev_p = tbl[i].exp_period;
    end

    // W1C of valid, then the next period re-sets it with a 1-cycle irq delay
    wr(2'd3, 32'd1);
    rd(2'd3, d);
    chk("w1c_status", d, 0);
    chk("w1c_irq", {31'b0, irq}, 0);
    pwm_set(1'b1);
    repeat (3) step();
    chk("irq_delay", {31'b0, irq}, 0);
    repeat (2) step();
    check_meas(last_high, last_period, 5, 1'b1);
    repeat (12) step();
    pwm_set(1'b0);
    repeat (10) step();

    // Enable (with clear) in the middle of a high pulse
    wr(2'd0, 32'd0);
    repeat (3) step();
    pwm_set(1'b1);
    repeat (10) step();
    wr(2'd0, 32'd7);
    repeat (20) step();
    pwm_set(1'b0);
    repeat (30) step();
    pwm_set(1'b1);
    repeat (5) step();
    rd(2'd3, d); chk("partial_status", d, 4);
    rd(2'd1, d); chk("partial_high", d, 0);
    rd(2'd2, d); chk("partial_period", d, 0);
    chk("partial_irq", {31'b0, irq}, 0);
    repeat (62) step();
    pwm_set(1'b0);
    repeat (30) step();
    run_period(70, 30, 1'b1, 1'b0, 70, 100);

    // Randomised periods against the timestamp model
    for (int i = 0; i < 12; i++) begin
      rh = $urandom_range(100, 8);
      rl = $urandom_range(100, 1);
      run_period(rh, rl, 1'b1, 1'b1, 0, 0);
    end

    // Saturation: hold pwm_in high
    wr(2'd3, 32'd3);
    pwm_set(1'b1);
    repeat (250) step();
    rd(2'd3, d); chk("sat_early_status", d, 5);
    repeat (49) step();
    rd(2'd3, d); chk("sat_status", d, 7);
    chk("sat_irq", {31'b0, irq}, 1);
    rd(2'd1, d); chk("sat_high", d, last_high);
    rd(2'd2, d); chk("sat_period", d, last_period);
    wr(2'd3, 32'd3);
    rd(2'd3, d); chk("sat_w1c_status", d, 4);
    chk("sat_w1c_irq", {31'b0, irq}, 0);
    pwm_set(1'b0);
    repeat (20) step();
    pwm_set(1'b1);
    repeat (5) step();
    rd(2'd3, d); chk("resume_first_rise", d, 4);
    repeat (24) step();
    pwm_set(1'b0);
    repeat (20) step();
    pwm_set(1'b1);
    repeat (5) step();
    check_meas(30, 50, 5, 1'b1);
    repeat (10) step();
    pwm_set(1'b0);
    repeat (10) step();

    // Reset during LOW
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      chk("midreset_read", d, 0);
    end
    chk("midreset_irq", {31'b0, irq}, 0);

    // clear with enable=0 mid-measurement
    wr(2'd0, 32'd3);
    repeat (5) step();
    run_period(20, 20, 1'b0, 1'b0, 0, 0);
    run_period(20, 20, 1'b0, 1'b0, 0, 0);
    pwm_set(1'b1);
    repeat (5) step();
    rd(2'd3, d); chk("preclear_status", d, 5);
    wr(2'd0, 32'd4);
    rd(2'd0, d); chk("clear_ctrl", d, 0);
    rd(2'd1, d); chk("clear_high", d, 0);
    rd(2'd2, d); chk("clear_period", d, 0);
    rd(2'd3, d); chk("clear_status", d, 4);
    chk("clear_irq", {31'b0, irq}, 0);
    wr(2'd1, 32'hFF);
    rd(2'd1, d); chk("ro_write_ignored", d, 0);
    pwm_set(1'b0);
    repeat (20) step();
    run_period(20, 20, 1'b0, 1'b0, 0, 0);
    run_period(20, 20, 1'b0, 1'b0, 0, 0);
    pwm_set(1'b1);
    repeat (5) step();
    rd(2'd3, d); chk("idle_status", d, 4);
    chk("idle_irq", {31'b0, irq}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
